fsm_burst_rd: RTL and testbench
===============================

# fsm_burst_rd

Parametrised burst-read handshake controller, the next generation of the team's single-beat read/delay/done FSM. On `go` it issues a burst of 1..2^BURST_W read beats. Each beat is a READ→DELAY pair. When `ws` is high in DELAY, the beat is retried, up to a bounded retry count, after which the burst aborts with `err`. It sits between a requester and a slow memory/peripheral port. All outputs are registered and decoded from the next state.

## Interface
- BURST_W, 4: width of `burst_len`; supports bursts of 1..2^BURST_W beats.
- MAX_RETRY, 3: maximum `ws` retries allowed per beat (≥1).
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled only in IDLE.
- burst_len  in  BURST_W  beat count, latched on go acceptance; 0 means 2^BURST_W.
- ws  in  1  wait/retry from target; sampled only in DELAY.
- rd  out  1  read strobe; high while state is READ or DELAY.
- ds  out  1  done strobe; one-cycle pulse, state DONE.
- err  out  1  retry-exhausted strobe; one-cycle pulse, state ERROR.
- busy  out  1  high whenever state ≠ IDLE.
- beat_cnt  out  BURST_W+1  beats completed in current/last burst.

## Operation
- States: IDLE, READ, DELAY, DONE, ERROR (5, 3-bit encoding).
- IDLE: go=1 → READ; latch remaining = (burst_len==0 ? 2^BURST_W : burst_len); clear beat_cnt and retry counter. go=0 → IDLE.
- READ → DELAY unconditionally.
- DELAY, ws=1, retry < MAX_RETRY → READ (same beat); retry += 1.
- DELAY, ws=1, retry == MAX_RETRY → ERROR; beat_cnt unchanged.
- DELAY, ws=0 → beat complete: beat_cnt += 1, remaining −= 1, retry cleared. If remaining was 1 → DONE; else → READ.
- DONE → IDLE. ERROR → IDLE.
- go is ignored outside IDLE. ws is ignored outside DELAY. burst_len is sampled only at go acceptance.
- Output register: on each edge, rd/ds/err/busy are loaded from the decode of state_next. Outputs therefore change on the same edge as the state and are glitch-free.
- beat_cnt holds its value after DONE/ERROR until the next go acceptance. Retry counter width is clog2(MAX_RETRY+1). beat_cnt never wraps, because its maximum is 2^BURST_W.

## Timing
- Reset (synchronous): at the next edge with reset=1, state=IDLE, rd=ds=err=busy=0, beat_cnt=0, retry=0. Reset takes priority over all inputs, including mid-burst. No ds/err is produced for an aborted burst.
- go sampled high at edge t: rd=1 and busy=1 from edge t.
- Zero-wait burst of N beats: rd high 2N cycles, ds high the single cycle after, busy high 2N+1 cycles. go may be re-accepted on the first cycle back in IDLE (2N+2 cycles after t), giving back-to-back bursts with one idle cycle.
- Each ws=1 in DELAY adds 2 cycles to that beat; rd stays continuously high.
- Exhaustion: the (MAX_RETRY+1)th ws=1 on one beat → err pulse for 1 cycle → IDLE. rd drops on the same edge err rises.
- ds and err are mutually exclusive and never coincide with rd.

## Test plan
- Reset mid-burst: go with burst_len=3, assert reset in 2nd DELAY → next edge all outputs 0, beat_cnt=0, no ds; a new go starts cleanly.
- Single beat, no wait: burst_len=1, go 1 cycle, ws=0 → rd high 2 cycles, ds 1 cycle, beat_cnt=1, busy 3 cycles.
- Full burst: burst_len=0 (BURST_W=4), ws=0 → rd high 32 cycles, ds once, beat_cnt=16.
- Retries within limit: burst_len=2, ws=1 on first 3 DELAYs of beat 1 (MAX_RETRY=3) → no err, rd high 2+6+2=10 cycles, ds, beat_cnt=2.
- Retry exhaustion: burst_len=4, beat 1 completes, ws=1 held on beat 2 → err pulse after 4th ws, beat_cnt=1, no ds, busy drops the next cycle.
- go held high continuously, burst_len changed mid-burst: length is the value latched at acceptance; exactly one idle cycle between consecutive bursts; ws toggled outside DELAY has no effect.

Source files
------------

// File: rtl/fsm_burst_rd.sv
// Burst-read handshake controller: issues 1..2^BURST_W READ/DELAY beats per go,
// retrying a beat on ws up to MAX_RETRY times before aborting with err.
module fsm_burst_rd #(
   parameter int BURST_W   = 4,
   parameter int MAX_RETRY = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               go,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               ws,
   output logic               rd,
   output logic               ds,
   output logic               err,
   output logic               busy,
   output logic [BURST_W:0]   beat_cnt
);

   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [BURST_W:0] FULL_LEN  = {1'b1, {BURST_W{1'b0}}};
   localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DELAY = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [BURST_W:0] remaining_q, remaining_d;
   logic [BURST_W:0] beat_cnt_q, beat_cnt_d;
   logic [RW-1:0]    retry_q, retry_d;
   logic             rd_q, rd_d;
   logic             ds_q, ds_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      beat_cnt_d  = beat_cnt_q;
      retry_d     = retry_q;
      case (state_q)
         IDLE: begin
            if (go) begin
               state_d     = READ;
               remaining_d = (burst_len == '0) ? FULL_LEN : {1'b0, burst_len};
               beat_cnt_d  = '0;
               retry_d     = '0;
            end
         end
         READ:  state_d = DELAY;
         DELAY: begin
            if (ws) begin
               if (retry_q < RETRY_MAX) begin
                  state_d = READ;
                  retry_d = retry_q + RW'(1);
               end else begin
                  state_d = ERROR;
               end
            end else begin
               beat_cnt_d  = beat_cnt_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               retry_d     = '0;
               state_d     = (remaining_q == (BURST_W+1)'(1)) ? DONE : READ;
            end
         end
         DONE:    state_d = IDLE;
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      rd_d   = (state_d == READ) || (state_d == DELAY);
      ds_d   = (state_d == DONE);
      err_d  = (state_d == ERROR);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         beat_cnt_q  <= '0;
         retry_q     <= '0;
         rd_q        <= 1'b0;
         ds_q        <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         beat_cnt_q  <= beat_cnt_d;
         retry_q     <= retry_d;
         rd_q        <= rd_d;
         ds_q        <= ds_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   assign rd       = rd_q;
   assign ds       = ds_q;
   assign err      = err_q;
   assign busy     = busy_q;
   assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fsm_burst_rd.sv
// Bench for fsm_burst_rd: each burst is described as a retry count per beat and
// expanded into the expected per-cycle output trace, checked at every negedge.
module tb_fsm_burst_rd;
   localparam int BURST_W   = 4;
   localparam int MAX_RETRY = 3;
   localparam int FULL      = 1 << BURST_W;

   logic               clock = 1'b0;
   logic               reset;
   logic               go;
   logic               ws;
   logic [BURST_W-1:0] burst_len;
   logic               rd, ds, err, busy;
   logic [BURST_W:0]   beat_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic             rd;
      logic             ds;
      logic             err;
      logic             busy;
      logic [BURST_W:0] cnt;
      logic             ws;
   } step_t;

   step_t trace[$];
   int    plan[FULL];

   always #5 clock = ~clock;

   fsm_burst_rd #(.BURST_W(BURST_W), .MAX_RETRY(MAX_RETRY)) dut (
      .clock(clock), .reset(reset), .go(go), .burst_len(burst_len), .ws(ws),
      .rd(rd), .ds(ds), .err(err), .busy(busy), .beat_cnt(beat_cnt)
   );

   function automatic step_t mk(logic r, logic d, logic e, logic b,
                                logic [BURST_W:0] c, logic w);
      step_t s;
      s.rd = r; s.ds = d; s.err = e; s.busy = b; s.cnt = c; s.ws = w;
      return s;
   endfunction

   // Expected trace: each attempt is a READ cycle then a DELAY cycle; the ws
   // value stored with a DELAY entry is what the bench drives during it.
   function automatic void build(int n);
      logic [BURST_W:0] cnt = '0;
      bit aborted = 0;
      trace.delete();
      for (int b = 0; b < n && !aborted; b++) begin
         if (plan[b] > MAX_RETRY) begin
            for (int a = 0; a <= MAX_RETRY; a++) begin
               trace.push_back(mk(1, 0, 0, 1, cnt, 1'($urandom)));
               trace.push_back(mk(1, 0, 0, 1, cnt, 1'b1));
            end
            aborted = 1;
         end else begin
            for (int a = 0; a < plan[b]; a++) begin
               trace.push_back(mk(1, 0, 0, 1, cnt, 1'($urandom)));
               trace.push_back(mk(1, 0, 0, 1, cnt, 1'b1));
            end
            trace.push_back(mk(1, 0, 0, 1, cnt, 1'($urandom)));
            trace.push_back(mk(1, 0, 0, 1, cnt, 1'b0));
            cnt = cnt + 1'b1;
         end
      end
      if (aborted) trace.push_back(mk(0, 0, 1, 1, cnt, 1'($urandom)));
      else         trace.push_back(mk(0, 1, 0, 1, cnt, 1'($urandom)));
      trace.push_back(mk(0, 0, 0, 0, cnt, 1'($urandom)));
   endfunction

   // Called in an IDLE cycle just after a negedge; ends in the IDLE cycle after the burst.
   task automatic run_burst(string tag, logic [BURST_W-1:0] len, bit keep_go);
      build((len == '0) ? FULL : int'(len));
      go = 1'b1; burst_len = len; ws = 1'($urandom);
      for (int k = 0; k < trace.size(); k++) begin
         @(negedge clock);
         n_cmp++;
         if ({rd, ds, err, busy, beat_cnt} !==
             {trace[k].rd, trace[k].ds, trace[k].err, trace[k].busy, trace[k].cnt}) begin
            n_bad++;
            $display("FAIL %s len=%0d cyc=%0d: got rd=%b ds=%b err=%b busy=%b cnt=%0d, want rd=%b ds=%b err=%b busy=%b cnt=%0d",
                     tag, len, k, rd, ds, err, busy, beat_cnt,
                     trace[k].rd, trace[k].ds, trace[k].err, trace[k].busy, trace[k].cnt);
         end
         ws = trace[k].ws;
         go = keep_go;
         if (keep_go) burst_len = BURST_W'($urandom);
      end
      $display("burst %s len=%0d cycles=%0d done", tag, len, trace.size());
   endtask

   task automatic test_reset();
      reset = 1'b1; go = 1'b1; ws = 1'b1; burst_len = '0;
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({rd, ds, err, busy, beat_cnt} !== '0) begin
         n_bad++;
         $display("FAIL reset: got rd=%b ds=%b err=%b busy=%b cnt=%0d, want all 0",
                  rd, ds, err, busy, beat_cnt);
      end
      reset = 1'b0; go = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_cmp++;
         if ({rd, ds, err, busy, beat_cnt} !== '0) begin
            n_bad++;
            $display("FAIL idle_no_go cyc=%0d: got rd=%b ds=%b err=%b busy=%b cnt=%0d, want all 0",
                     i, rd, ds, err, busy, beat_cnt);
         end
      end
      $display("reset checks done");
   endtask

   task automatic test_reset_mid_burst();
      go = 1'b1; burst_len = 3; ws = 1'b0;
      @(negedge clock); go = 1'b0;       // READ, beat 1
      @(negedge clock);                  // DELAY, beat 1
      @(negedge clock);                  // READ, beat 2
      @(negedge clock);                  // DELAY, beat 2
      n_cmp++;
      if ({rd, busy, beat_cnt} !== {1'b1, 1'b1, (BURST_W+1)'(1)}) begin
         n_bad++;
         $display("FAIL pre_reset: got rd=%b busy=%b cnt=%0d, want rd=1 busy=1 cnt=1",
                  rd, busy, beat_cnt);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      n_cmp++;
      if ({rd, ds, err, busy, beat_cnt} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset: got rd=%b ds=%b err=%b busy=%b cnt=%0d, want all 0",
                  rd, ds, err, busy, beat_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         n_cmp++;
         if ({rd, ds, err, busy} !== 4'b0) begin
            n_bad++;
            $display("FAIL post_reset cyc=%0d: got rd=%b ds=%b err=%b busy=%b, want all 0",
                     i, rd, ds, err, busy);
         end
      end
      for (int b = 0; b < FULL; b++) plan[b] = 0;
      run_burst("after_reset", 3, 0);
   endtask

   task automatic test_single();
      for (int b = 0; b < FULL; b++) plan[b] = 0;
      run_burst("single", 1, 0);
   endtask

   task automatic test_full();
      for (int b = 0; b < FULL; b++) plan[b] = 0;
      run_burst("full", 0, 0);
   endtask

   task automatic test_retry();
      for (int b = 0; b < FULL; b++) plan[b] = 0;
      plan[0] = MAX_RETRY;
      run_burst("retry_ok", 2, 0);
   endtask

   task automatic test_exhaust();
      for (int b = 0; b < FULL; b++) plan[b] = 0;
      plan[1] = MAX_RETRY + 1;
      run_burst("exhaust", 4, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         for (int b = 0; b < FULL; b++) plan[b] = int'($urandom_range(0, 2));
         run_burst("back_to_back", BURST_W'($urandom_range(0, 5)), i < 5);
      end
      go = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         for (int b = 0; b < FULL; b++)
            plan[b] = ($urandom_range(0, 9) == 0) ? MAX_RETRY + 1
                                                  : int'($urandom_range(0, MAX_RETRY));
         run_burst("random", BURST_W'($urandom), 0);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clock);
            go = 1'b0;
            ws = 1'($urandom);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_burst();
      test_single();
      test_full();
      test_retry();
      test_exhaust();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
